// File: rtl/mmul_pkg.sv
// Shared types, default dimensions and width helper for the matrix-multiply sequencer.
package mmul_pkg;

  localparam int RA_MAX_DEF = 8;
  localparam int CA_MAX_DEF = 8;
  localparam int CB_MAX_DEF = 8;
  localparam int LAT_DEF    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Bits needed to index n entries, never less than one.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mmul_wrap_counter.sv
// Up-counter with a run-time last value; folds back to zero and flags the wrap
// so several instances can be chained as carry stages.
module mmul_wrap_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_r;

  assign wrap = en && (cnt_r == last);
  assign cnt  = cnt_r;

  // Count register: clear wins, wrap folds to zero, enable steps by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (wrap) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/mmul_sequencer.sv
// Run-time controller for the single-MAC matrix multiply: latches the job
// dimensions on start, steps (i, j, k) with k fastest, waits out the datapath
// latency and pulses completed.
module mmul_sequencer
  import mmul_pkg::*;
#(
  parameter int RA_MAX = RA_MAX_DEF,
  parameter int CA_MAX = CA_MAX_DEF,
  parameter int CB_MAX = CB_MAX_DEF,
  parameter int LAT    = LAT_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          stall,
  input  logic [$clog2(RA_MAX+1)-1:0]   cfg_ra,
  input  logic [$clog2(CA_MAX+1)-1:0]   cfg_ca,
  input  logic [$clog2(CB_MAX+1)-1:0]   cfg_cb,
  output logic                          mac_valid,
  output logic [idx_w(RA_MAX)-1:0]      idx_i,
  output logic [idx_w(CB_MAX)-1:0]      idx_j,
  output logic [idx_w(CA_MAX)-1:0]      idx_k,
  output logic                          acc_clr,
  output logic                          acc_wr,
  output logic                          busy,
  output logic                          completed,
  output logic                          err
);

  localparam int RW     = $clog2(RA_MAX+1);
  localparam int CW     = $clog2(CA_MAX+1);
  localparam int BW     = $clog2(CB_MAX+1);
  localparam int IW     = idx_w(RA_MAX);
  localparam int JW     = idx_w(CB_MAX);
  localparam int KW     = idx_w(CA_MAX);
  localparam int DW     = idx_w(LAT+1);
  localparam int LAT_M1 = (LAT > 0) ? (LAT - 1) : 0;

  state_t          state_r, state_s;
  logic [RW-1:0]   ra_r;
  logic [CW-1:0]   ca_r;
  logic [BW-1:0]   cb_r;
  logic [DW-1:0]   drain_r;
  logic            mac_valid_r, busy_r, completed_r, err_r;
  logic            cfg_ok_s, start_ok_s, start_bad_s, accept_s, clr_s;
  logic            k_wrap_s, j_wrap_s, i_wrap_s;
  logic [IW-1:0]   i_s, i_last_s;
  logic [JW-1:0]   j_s, j_last_s;
  logic [KW-1:0]   k_s, k_last_s;

  assign cfg_ok_s    = (cfg_ra != '0) && (cfg_ra <= RW'(RA_MAX)) &&
                       (cfg_ca != '0) && (cfg_ca <= CW'(CA_MAX)) &&
                       (cfg_cb != '0) && (cfg_cb <= BW'(CB_MAX));
  assign start_ok_s  = (state_r == ST_IDLE) && start && !abort && cfg_ok_s;
  assign start_bad_s = (state_r == ST_IDLE) && start && !abort && !cfg_ok_s;
  // Abort beats acceptance, so a cancelled cycle never advances the indices.
  assign accept_s    = (state_r == ST_RUN) && !stall && !abort;
  assign clr_s       = start_ok_s ||
                       (((state_r == ST_RUN) || (state_r == ST_DRAIN)) && abort);

  assign i_last_s = IW'(ra_r - RW'(1'b1));
  assign j_last_s = JW'(cb_r - BW'(1'b1));
  assign k_last_s = KW'(ca_r - CW'(1'b1));

  mmul_wrap_counter #(.W(KW)) u_cnt_k (
    .clk(clk), .rst_n(rst_n), .clr(clr_s), .en(accept_s),
    .last(k_last_s), .cnt(k_s), .wrap(k_wrap_s)
  );
  mmul_wrap_counter #(.W(JW)) u_cnt_j (
    .clk(clk), .rst_n(rst_n), .clr(clr_s), .en(k_wrap_s),
    .last(j_last_s), .cnt(j_s), .wrap(j_wrap_s)
  );
  // i wraps only on acceptance of the final triple of the job.
  mmul_wrap_counter #(.W(IW)) u_cnt_i (
    .clk(clk), .rst_n(rst_n), .clr(clr_s), .en(j_wrap_s),
    .last(i_last_s), .cnt(i_s), .wrap(i_wrap_s)
  );

  // Next-state logic for the job sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else if (i_wrap_s) begin
          state_s = (LAT == 0) ? ST_DONE : ST_DRAIN;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else if (drain_r == '0) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Job dimensions are captured once at an accepted start and held for the job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_r <= '0;
      ca_r <= '0;
      cb_r <= '0;
    end else if (start_ok_s) begin
      ra_r <= cfg_ra;
      ca_r <= cfg_ca;
      cb_r <= cfg_cb;
    end else begin
      ra_r <= ra_r;
      ca_r <= ca_r;
      cb_r <= cb_r;
    end
  end

  // Drain down-counter: loaded with LAT-1 on the last issue, exits DRAIN at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_r <= '0;
    end else if ((state_r == ST_RUN) && i_wrap_s) begin
      drain_r <= DW'(LAT_M1);
    end else if ((state_r == ST_DRAIN) && (drain_r != '0)) begin
      drain_r <= drain_r - DW'(1'b1);
    end else begin
      drain_r <= drain_r;
    end
  end

  // Status flags registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      completed_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      mac_valid_r <= (state_s == ST_RUN);
      busy_r      <= (state_s != ST_IDLE);
      completed_r <= (state_s == ST_DONE);
      err_r       <= start_bad_s;
    end
  end

  assign mac_valid = mac_valid_r;
  assign busy      = busy_r;
  assign completed = completed_r;
  assign err       = err_r;
  assign idx_i     = i_s;
  assign idx_j     = j_s;
  assign idx_k     = k_s;
  assign acc_clr   = mac_valid_r && (k_s == '0);
  assign acc_wr    = mac_valid_r && (k_s == k_last_s);

endmodule

// File: tb/tb_mmul_sequencer.sv
// Bench for mmul_sequencer: table of jobs plus randomized jobs, each checked
// cycle by cycle against a triple-list model, with a C = A*B product check.
module tb_mmul_sequencer;

  typedef struct packed {
    logic       mv;
    logic [2:0] i;
    logic [2:0] j;
    logic [2:0] k;
    logic       clr;
    logic       wr;
    logic       busy;
    logic       comp;
    logic       err;
  } out_t;

  typedef struct {
    int sel; int ra; int ca; int cb;
    int slo; int shi; int pct;
    int abc; int stc; int exp_comp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0, abort = 1'b0, stall = 1'b0;
  logic [3:0] cfg_ra = 4'd0, cfg_ca = 4'd0, cfg_cb = 4'd0;
  logic       mv_a, clr_a, wr_a, busy_a, comp_a, err_a;
  logic       mv_b, clr_b, wr_b, busy_b, comp_b, err_b;
  logic [2:0] i_a, j_a, k_a, i_b, j_b, k_b;
  int         n_chk = 0;
  int         n_pass = 0;
  out_t       m_all, m_noidx;
  vec_t       tbl[12];

  always #5 clk = ~clk;

  mmul_sequencer #(.RA_MAX(8), .CA_MAX(8), .CB_MAX(8), .LAT(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .stall(stall),
    .cfg_ra(cfg_ra), .cfg_ca(cfg_ca), .cfg_cb(cfg_cb),
    .mac_valid(mv_a), .idx_i(i_a), .idx_j(j_a), .idx_k(k_a),
    .acc_clr(clr_a), .acc_wr(wr_a), .busy(busy_a), .completed(comp_a), .err(err_a)
  );

  mmul_sequencer #(.RA_MAX(8), .CA_MAX(8), .CB_MAX(8), .LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .stall(stall),
    .cfg_ra(cfg_ra), .cfg_ca(cfg_ca), .cfg_cb(cfg_cb),
    .mac_valid(mv_b), .idx_i(i_b), .idx_j(j_b), .idx_k(k_b),
    .acc_clr(clr_b), .acc_wr(wr_b), .busy(busy_b), .completed(comp_b), .err(err_b)
  );

  function automatic out_t get_out(input int sel);
    out_t o;
    if (sel == 0) o = {mv_a, i_a, j_a, k_a, clr_a, wr_a, busy_a, comp_a, err_a};
    else          o = {mv_b, i_b, j_b, k_b, clr_b, wr_b, busy_b, comp_b, err_b};
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string nm, input int cyc, input out_t got,
                           input out_t exp, input out_t msk);
    n_chk++;
    if (((got ^ exp) & msk) == '0) n_pass++;
    else $display("FAIL %s cycle %0d: actual %h required %h (compared bits %h)",
                  nm, cyc, got, exp, msk);
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", nm, got, exp);
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start_a = v;
    else          start_b = v;
  endtask

  // Runs one job from its start pulse to the first IDLE cycle afterwards.
  task automatic run_job(input int sel, input int ra, input int ca, input int cb,
                         input int slo, input int shi, input int pct,
                         input int abc, input int stc, output int comp_cyc);
    int lat, n, p, d, phase, cyc, acc, bad, sum;
    bit st, ab, finished, aborted;
    out_t got, exp;
    int ti[$], tj[$], tk[$];
    int a[8][8], b[8][8], c[8][8];
    lat = (sel == 0) ? 2 : 0;
    n = ra * ca * cb;
    for (int i = 0; i < ra; i++)
      for (int j = 0; j < cb; j++)
        for (int k = 0; k < ca; k++) begin
          ti.push_back(i); tj.push_back(j); tk.push_back(k);
        end
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++) begin
        a[x][y] = int'($urandom_range(15));
        b[x][y] = int'($urandom_range(15));
        c[x][y] = -1;
      end
    acc = 0;
    cfg_ra = 4'(ra); cfg_ca = 4'(ca); cfg_cb = 4'(cb);
    set_start(sel, 1'b1);
    tick();
    set_start(sel, 1'b0);
    cfg_ra = 4'($urandom_range(15)); cfg_ca = 4'($urandom_range(15));
    cfg_cb = 4'($urandom_range(15));
    cyc = 1; comp_cyc = -1; p = 0; d = 0; phase = 0;
    finished = 1'b0; aborted = 1'b0;
    while (!finished && cyc < 3000) begin
      exp = '0; exp.busy = 1'b1;
      if (phase == 0) begin
        exp.mv = 1'b1; exp.i = 3'(ti[p]); exp.j = 3'(tj[p]); exp.k = 3'(tk[p]);
        exp.clr = (tk[p] == 0); exp.wr = (tk[p] == ca - 1);
      end else if (phase == 2) begin
        exp.comp = 1'b1;
      end
      got = get_out(sel);
      check_out("job_cycle", cyc, got, exp, (phase == 0) ? m_all : m_noidx);
      if (got.comp) comp_cyc = cyc;
      st = ((cyc >= slo) && (cyc <= shi)) || (int'($urandom_range(99)) < pct);
      ab = (cyc == abc);
      if (got.mv && !st && !ab) begin
        if (got.clr) acc = a[got.i][got.k] * b[got.k][got.j];
        else         acc = acc + a[got.i][got.k] * b[got.k][got.j];
        if (got.wr) c[got.i][got.j] = acc;
      end
      stall = st; abort = ab;
      if (cyc == stc) set_start(sel, 1'b1);
      tick();
      cyc++;
      set_start(sel, 1'b0);
      stall = 1'b0; abort = 1'b0;
      if (ab && phase != 2) begin
        check_out("abort_idle", cyc, get_out(sel), '0, m_all);
        aborted = 1'b1; finished = 1'b1;
      end else if (phase == 0) begin
        if (!st) begin
          p++;
          if (p == n) phase = (lat == 0) ? 2 : 1;
        end
      end else if (phase == 1) begin
        d++;
        if (d == lat) phase = 2;
      end else begin
        check_out("idle_after_done", cyc, get_out(sel), '0, m_noidx);
        finished = 1'b1;
      end
    end
    if (!finished) check_int("job_timeout", cyc, -1);
    if (!aborted) begin
      bad = 0;
      for (int i = 0; i < ra; i++)
        for (int j = 0; j < cb; j++) begin
          sum = 0;
          for (int k = 0; k < ca; k++) sum += a[i][k] * b[k][j];
          if (c[i][j] != sum) bad++;
        end
      check_int("product_mismatches", bad, 0);
    end
  endtask

  initial begin
    int comp, sel, ra, ca, cb, n, lat, abc, stc;
    out_t e;

    m_all = '1;
    m_noidx = '0;
    m_noidx.mv = 1'b1; m_noidx.busy = 1'b1; m_noidx.comp = 1'b1; m_noidx.err = 1'b1;

    //           sel ra ca cb slo shi pct abc stc exp_comp
    tbl[0]  = '{0, 2, 3, 2, 0, -1, 0, 0,  0, 15};
    tbl[1]  = '{0, 2, 3, 2, 3,  5, 0, 0,  4, 18};
    tbl[2]  = '{0, 2, 3, 2, 0, -1, 0, 5,  0, -1};
    tbl[3]  = '{0, 2, 3, 2, 0, -1, 0, 13, 0, -1};
    tbl[4]  = '{0, 2, 3, 2, 0, -1, 0, 15, 0, 15};
    tbl[5]  = '{1, 1, 1, 1, 0, -1, 0, 0,  0, 2};
    tbl[6]  = '{1, 1, 1, 1, 0, -1, 0, 0,  0, 2};
    tbl[7]  = '{1, 2, 3, 2, 0, -1, 0, 0,  0, 13};
    tbl[8]  = '{0, 8, 8, 8, 0, -1, 0, 0,  0, 515};
    tbl[9]  = '{0, 1, 1, 1, 0, -1, 0, 0,  0, 4};
    tbl[10] = '{0, 3, 1, 4, 0, -1, 0, 0,  0, 15};
    tbl[11] = '{1, 2, 3, 2, 0, -1, 0, 12, 0, -1};

    // Reset state.
    #2 rst_n = 1'b0;
    tick(); tick();
    check_out("reset_a", 0, get_out(0), '0, m_all);
    check_out("reset_b", 0, get_out(1), '0, m_all);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Rejected configurations.
    cfg_ra = 4'd2; cfg_ca = 4'd0; cfg_cb = 4'd2; start_a = 1'b1;
    tick(); start_a = 1'b0;
    e = '0; e.err = 1'b1;
    check_out("err_ca0", 1, get_out(0), e, m_noidx);
    tick();
    check_out("err_ca0_clears", 2, get_out(0), '0, m_noidx);
    cfg_ra = 4'd9; cfg_ca = 4'd3; cfg_cb = 4'd2; start_a = 1'b1;
    tick(); start_a = 1'b0;
    check_out("err_ra9", 1, get_out(0), e, m_noidx);
    cfg_ra = 4'd1; cfg_ca = 4'd1; cfg_cb = 4'd9; start_b = 1'b1;
    tick(); start_b = 1'b0;
    check_out("err_cb9_lat0", 1, get_out(1), e, m_noidx);
    // Abort in IDLE wins over start.
    cfg_ra = 4'd2; cfg_ca = 4'd2; cfg_cb = 4'd2; start_a = 1'b1; abort = 1'b1;
    tick(); start_a = 1'b0; abort = 1'b0;
    check_out("abort_beats_start", 1, get_out(0), '0, m_noidx);
    tick();
    check_out("abort_beats_start_idle", 2, get_out(0), '0, m_noidx);

    // Table of directed jobs, run back to back.
    for (int t = 0; t < 12; t++) begin
      run_job(tbl[t].sel, tbl[t].ra, tbl[t].ca, tbl[t].cb, tbl[t].slo, tbl[t].shi,
              tbl[t].pct, tbl[t].abc, tbl[t].stc, comp);
      check_int($sformatf("completed_cycle_vec%0d", t), comp, tbl[t].exp_comp);
    end

    // Asynchronous reset in the middle of a job.
    cfg_ra = 4'd8; cfg_ca = 4'd8; cfg_cb = 4'd8; start_a = 1'b1;
    tick(); start_a = 1'b0;
    tick(); tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check_out("async_reset_a", 0, get_out(0), '0, m_all);
    check_out("async_reset_b", 0, get_out(1), '0, m_all);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check_out("after_reset_idle", 0, get_out(0), '0, m_all);
    run_job(0, 2, 2, 2, 0, -1, 0, 0, 0, comp);
    check_int("completed_cycle_after_reset", comp, 11);

    // Randomized jobs with random stalls, aborts and ignored starts.
    for (int r = 0; r < 25; r++) begin
      sel = int'($urandom_range(1));
      ra = int'($urandom_range(4, 1));
      ca = int'($urandom_range(4, 1));
      cb = int'($urandom_range(4, 1));
      n = ra * ca * cb;
      lat = (sel == 0) ? 2 : 0;
      abc = ($urandom_range(3) == 0) ? int'($urandom_range(n + lat + 1, 1)) : 0;
      stc = ($urandom_range(1) == 0) ? int'($urandom_range(n, 1)) : 0;
      run_job(sel, ra, ca, cb, 0, -1, 30, abc, stc, comp);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
